host_from_breakout: RTL and testbench
=====================================

HOST_FROM_BREAKOUT -- requirements
Module: host_from_breakout

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: i_clk cycles without a serial-clock rising edge before lock is dropped.
REQ-002 SHALL have parameter MISS_LIMIT, default 2: consecutive bad sync words in LOCKED before returning to HUNT.
REQ-003 SHALL have port i_clk  input  1  system clock; the only clock.
REQ-004 SHALL have port i_reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_clk_s  input  1  serial clock from breakout, asynchronous to i_clk.
REQ-006 SHALL have port i_d0_s  input  1  serial lane 0 (sync + port).
REQ-007 SHALL have port i_d1_s  input  1  serial lane 1 (link power + button).
REQ-008 SHALL have port o_port  output  8  last good port word.
REQ-009 SHALL have port o_button  output  8  last good button word.
REQ-010 SHALL have port o_link_pow  output  4  last good link-power word.
REQ-011 SHALL have port o_valid  output  1  one-cycle pulse when outputs update.
REQ-012 SHALL have port o_locked  output  1  high in LOCKED state.
REQ-013 SHALL have port o_frame_err  output  1  one-cycle pulse on bad sync at a frame boundary in VERIFY or LOCKED.

Function
REQ-014 Frame SHALL be 12 serial bits per lane, MSB first; lanes sampled on i_clk_s rising edge.
REQ-015 Lane 0 SHALL carry {4'b1110 sync, port[7:0]}; lane 1 SHALL carry {link_pow[3:0], button[7:0]}.
REQ-016 All three serial inputs SHALL pass through 2-FF synchronizers; i_clk_s SHALL be at most i_clk/4.
REQ-017 A bit strobe SHALL be a 0->1 transition on synchronized i_clk_s; on each strobe both lanes shift into 12-bit shift registers.
REQ-018 Bit counter SHALL count strobes 0..11 and wrap to 0 on the 12th; the frame boundary is the strobe that wraps.
REQ-019 States SHALL be HUNT, VERIFY, LOCKED; reset enters HUNT.
REQ-020 HUNT: after every strobe, if lane-0 shift register bits [11:8] == 4'b1110, clear bit counter and go VERIFY.
REQ-021 VERIFY: at frame boundary, sync match -> LOCKED and update outputs; mismatch -> HUNT and pulse o_frame_err.
REQ-022 LOCKED: at frame boundary, sync match -> update outputs and clear miss counter; mismatch -> pulse o_frame_err, hold outputs, increment miss counter.
REQ-023 LOCKED: miss counter reaching MISS_LIMIT SHALL go HUNT and clear the counter.
REQ-024 Output update SHALL load o_port, o_button, o_link_pow from the shift registers and pulse o_valid for exactly one i_clk cycle.
REQ-025 o_valid SHALL assert 4 i_clk cycles after the first i_clk edge sampling i_clk_s high for the 12th bit.
REQ-026 Idle counter SHALL clear on each strobe, otherwise increment, saturating at TIMEOUT_CYCLES; reaching it in any state -> HUNT, bit counter cleared.
REQ-027 Strobe and timeout in the same cycle: strobe wins, counter clears, no state change from timeout.
REQ-028 Data outputs SHALL hold last good values in HUNT and through timeouts; they SHALL never update on a mismatched frame.
REQ-029 o_locked SHALL be registered and equal (state == LOCKED).

Reset
REQ-030 Reset assertion SHALL immediately force o_port=0, o_button=0, o_link_pow=0, o_valid=0, o_locked=0, o_frame_err=0.
REQ-031 Reset SHALL clear synchronizers, shift registers, bit, miss and idle counters, and set state HUNT, including mid-frame.
REQ-032 Reset deassertion SHALL be used as-is; the upstream reset source is responsible for synchronous release.

Structure
REQ-033 Shared package SHALL hold FRAME_BITS=12, SYNC_WORD=4'b1110, field widths 8/8/4, and the state enum.
REQ-034 One sub-module, serial_sync (2-FF synchronizer plus rising-edge strobe for i_clk_s), SHALL be instantiated.

Verification
REQ-035 Reset, then three frames port=F0 button=AA link_pow=8 -> LOCKED after frame 2, o_valid pulses, outputs F0/AA/8.
REQ-036 LOCKED, then frame link_pow=F -> outputs F0/AA/F on next o_valid, exact REQ-025 latency checked.
REQ-037 LOCKED, one frame with sync 4'b0110 -> o_frame_err pulse, outputs held, o_locked stays 1; a second bad frame -> o_locked 0.
REQ-038 LOCKED, i_clk_s stopped 1100 cycles -> o_locked 0 at cycle 1024, outputs held F0/AA/F.
REQ-039 i_reset_n low at bit 6 of a frame -> all outputs 0 at once; after release and two clean frames -> relock.
REQ-040 Random port data containing 1110 patterns, stream starting mid-frame -> correct lock to true boundary within 3 frames.

Source files
------------

// File: rtl/host_from_breakout_pkg.sv
// Shared constants, field widths and state encoding
// for the breakout serial frame receiver.
package host_from_breakout_pkg;

  localparam int FRAME_BITS = 12;
  localparam int SYNC_W = 4;
  localparam logic [SYNC_W-1:0] SYNC_WORD = 4'b1110;
  localparam int PORT_W = 8;
  localparam int BUTTON_W = 8;
  localparam int LINK_W = 4;
  localparam int CNT_W = $clog2(FRAME_BITS);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic sync_ok(
    input logic [FRAME_BITS-1:0] w
  );
    return w[FRAME_BITS-1 -: SYNC_W] == SYNC_WORD;
  endfunction

endpackage

// File: rtl/serial_sync.sv
// Brings the breakout serial clock and lanes into the i_clk
// domain and produces a one-cycle strobe per serial rising edge.
module serial_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_s,
  input  logic d0_s,
  input  logic d1_s,
  output logic strobe,
  output logic d0,
  output logic d1
);

  logic [2:0] cs;
  logic [1:0] a0;
  logic [1:0] a1;

  // Two-flop synchronizers; data is re-registered so it
  // lines up with the strobe derived from the clock chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs     <= '0;
      a0     <= '0;
      a1     <= '0;
      strobe <= 1'b0;
      d0     <= 1'b0;
      d1     <= 1'b0;
    end else begin
      cs     <= {cs[1:0], clk_s};
      a0     <= {a0[0], d0_s};
      a1     <= {a1[0], d1_s};
      strobe <= cs[1] & ~cs[2];
      d0     <= a0[1];
      d1     <= a1[1];
    end
  end

endmodule

// File: rtl/host_from_breakout.sv
// Breakout frame receiver: hunts for the sync word, verifies
// alignment, then publishes port/button/link-power words.
module host_from_breakout
  import host_from_breakout_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MISS_LIMIT = 2
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_clk_s,
  input  logic                i_d0_s,
  input  logic                i_d1_s,
  output logic [PORT_W-1:0]   o_port,
  output logic [BUTTON_W-1:0] o_button,
  output logic [LINK_W-1:0]   o_link_pow,
  output logic                o_valid,
  output logic                o_locked,
  output logic                o_frame_err
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

  logic                  strobe;
  logic                  d0;
  logic                  d1;
  logic [FRAME_BITS-1:0] sr0;
  logic [FRAME_BITS-1:0] sr1;
  logic [CNT_W-1:0]      bit_cnt;
  logic [IDLE_W-1:0]     idle;
  logic [MISS_W-1:0]     miss;
  logic                  shifted;
  logic                  boundary;
  logic                  timeout;
  logic                  good;
  state_t                state;

  // A strobe in the same cycle always beats the timeout
  assign timeout = (idle == IDLE_MAX) && !strobe;
  assign good = sync_ok(sr0);

  serial_sync u_sync (
    .clk    (i_clk),
    .rst_n  (i_reset_n),
    .clk_s  (i_clk_s),
    .d0_s   (i_d0_s),
    .d1_s   (i_d1_s),
    .strobe (strobe),
    .d0     (d0),
    .d1     (d1)
  );

  // Shift both lanes per strobe; count i_clk cycles since the last one
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sr0      <= '0;
      sr1      <= '0;
      idle     <= '0;
      shifted  <= 1'b0;
      boundary <= 1'b0;
    end else begin
      shifted  <= strobe;
      boundary <= strobe && (bit_cnt == LAST_BIT);
      if (strobe) begin
        sr0  <= {sr0[FRAME_BITS-2:0], d0};
        sr1  <= {sr1[FRAME_BITS-2:0], d1};
        idle <= '0;
      end else if (idle != IDLE_MAX) begin
        idle <= idle + 1'b1;
      end
    end
  end

  // Framing FSM, acting the cycle after the shift registers update
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= HUNT;
      bit_cnt     <= '0;
      miss        <= '0;
      o_port      <= '0;
      o_button    <= '0;
      o_link_pow  <= '0;
      o_valid     <= 1'b0;
      o_locked    <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      if (strobe) begin
        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
      end
      if (timeout) begin
        state    <= HUNT;
        o_locked <= 1'b0;
        bit_cnt  <= '0;
        miss     <= '0;
      end else if (shifted) begin
        unique case (state)
          HUNT: begin
            if (good) begin
              bit_cnt <= '0;
              state   <= VERIFY;
            end
          end
          VERIFY: begin
            if (boundary && good) begin
              state      <= LOCKED;
              o_locked   <= 1'b1;
              o_valid    <= 1'b1;
              o_port     <= sr0[PORT_W-1:0];
              o_button   <= sr1[BUTTON_W-1:0];
              o_link_pow <= sr1[FRAME_BITS-1 -: LINK_W];
              miss       <= '0;
            end else if (boundary) begin
              state       <= HUNT;
              o_frame_err <= 1'b1;
            end
          end
          LOCKED: begin
            if (boundary && good) begin
              o_valid    <= 1'b1;
              o_port     <= sr0[PORT_W-1:0];
              o_button   <= sr1[BUTTON_W-1:0];
              o_link_pow <= sr1[FRAME_BITS-1 -: LINK_W];
              miss       <= '0;
            end else if (boundary) begin
              o_frame_err <= 1'b1;
              if (int'(miss) + 1 >= MISS_LIMIT) begin
                state    <= HUNT;
                o_locked <= 1'b0;
                miss     <= '0;
              end else begin
                miss <= miss + 1'b1;
              end
            end
          end
          default: begin
            state    <= HUNT;
            o_locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_host_from_breakout.sv
// Scoreboard bench: frames push expected words, a negedge
// monitor pops and compares on every o_valid pulse.
module tb_host_from_breakout;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_s = 1'b0;
  logic       d0 = 1'b0;
  logic       d1 = 1'b0;
  logic [7:0] o_port;
  logic [7:0] o_button;
  logic [3:0] o_link_pow;
  logic       o_valid;
  logic       o_locked;
  logic       o_frame_err;

  typedef struct packed {
    logic [7:0] port;
    logic [7:0] button;
    logic [3:0] link;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   err_seen = 0;
  int   err_exp = 0;
  int   valid_cyc = 0;
  int   rise_cyc = 0;

  host_from_breakout dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_clk_s     (clk_s),
    .i_d0_s      (d0),
    .i_d1_s      (d1),
    .o_port      (o_port),
    .o_button    (o_button),
    .o_link_pow  (o_link_pow),
    .o_valid     (o_valid),
    .o_locked    (o_locked),
    .o_frame_err (o_frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: scoreboard pop on o_valid, count frame errors
  always @(negedge clk) begin
    if (o_frame_err) err_seen++;
    if (o_valid) begin
      check("valid_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        valid_cyc = cyc;
        check("valid_port", o_port, e.port);
        check("valid_button", o_button, e.button);
        check("valid_link", o_link_pow, e.link);
      end
    end
  end

  task automatic send_bit(input logic b0, input logic b1);
    d0 = b0;
    d1 = b1;
    repeat (3) @(posedge clk);
    #1 clk_s = 1'b1;
    rise_cyc = cyc;
    repeat (3) @(posedge clk);
    #1 clk_s = 1'b0;
  endtask

  task automatic send_bits(input logic [11:0] w0,
                           input logic [11:0] w1,
                           input int first, input int last);
    for (int i = first; i <= last; i++)
      send_bit(w0[11-i], w1[11-i]);
  endtask

  task automatic frame(input logic [3:0] sync,
                       input logic [7:0] port,
                       input logic [7:0] button,
                       input logic [3:0] link,
                       input bit push);
    exp_t x;
    x.port = port;
    x.button = button;
    x.link = link;
    if (push) exp_q.push_back(x);
    send_bits({sync, port}, {link, button}, 0, 11);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_outs(input string tag,
                            input logic [7:0] p,
                            input logic [7:0] b,
                            input logic [3:0] l);
    check({tag, "_port"}, o_port, p);
    check({tag, "_button"}, o_button, b);
    check({tag, "_link"}, o_link_pow, l);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clk_s = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_outs("reset", 8'h00, 8'h00, 4'h0);
    check("reset_valid", o_valid, 0);
    check("reset_locked", o_locked, 0);
    check("reset_frame_err", o_frame_err, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    frame(4'hE, 8'hF0, 8'hAA, 4'h8, 0);
    check("locked_after_f1", o_locked, 0);
    frame(4'hE, 8'hF0, 8'hAA, 4'h8, 1);
    check("locked_after_f2", o_locked, 1);
    frame(4'hE, 8'hF0, 8'hAA, 4'h8, 1);

    frame(4'hE, 8'hF0, 8'hAA, 4'hF, 1);
    check("valid_latency", valid_cyc - rise_cyc, 5);
    check_outs("linkf", 8'hF0, 8'hAA, 4'hF);

    repeat (1000) @(negedge clk);
    check("idle_1000_locked", o_locked, 1);
    repeat (100) @(negedge clk);
    check("idle_1100_locked", o_locked, 0);
    check_outs("timeout_held", 8'hF0, 8'hAA, 4'hF);

    send_bits({4'hE, 8'hF0}, {4'h8, 8'hAA}, 0, 5);
    #2 rst_n = 1'b0;
    #1;
    check_outs("midreset", 8'h00, 8'h00, 4'h0);
    check("midreset_valid", o_valid, 0);
    check("midreset_locked", o_locked, 0);
    check("midreset_frame_err", o_frame_err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    frame(4'hE, 8'hF0, 8'hAA, 4'h8, 0);
    frame(4'hE, 8'hF0, 8'hAA, 4'h8, 1);
    check("relock_locked", o_locked, 1);

    frame(4'h6, 8'hF0, 8'hAA, 4'h8, 0);
    err_exp++;
    check("bad1_err_count", err_seen, err_exp);
    check("bad1_locked", o_locked, 1);
    check_outs("bad1_held", 8'hF0, 8'hAA, 4'h8);
    frame(4'h6, 8'h12, 8'h34, 4'h5, 0);
    err_exp++;
    check("bad2_err_count", err_seen, err_exp);
    check("bad2_locked", o_locked, 0);
    check_outs("bad2_held", 8'hF0, 8'hAA, 4'h8);

    do_reset();
    send_bits({4'hE, 8'hE0}, {4'h1, 8'h23}, 4, 11);
    frame(4'hE, 8'h00, 8'h11, 4'h2, 0);
    err_exp++;
    frame(4'hE, 8'hEE, 8'h22, 4'h3, 0);
    check("hunt_err_count", err_seen, err_exp);
    check("hunt_not_locked", o_locked, 0);
    frame(4'hE, 8'h5E, 8'h3C, 4'h6, 1);
    check("hunt_locked", o_locked, 1);
    frame(4'hE, 8'hE7, 8'hC3, 4'h9, 1);
    check_outs("hunt_final", 8'hE7, 8'hC3, 4'h9);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++)
      @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("frame_err_total", err_seen, err_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
